// File: rtl/uart_tx_arb.sv
// Four-way round-robin arbiter feeding one UART transmitter.
// A grant is held for a whole packet (or HOLD_MAX bytes), then passes on.
module uart_tx_arb #(
  parameter int unsigned HOLD_MAX = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_last,
  output logic [3:0]  ack,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic [1:0]  owner,
  output logic        owner_valid
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

  localparam logic [7:0] HOLD_MAX_B = 8'(HOLD_MAX);

  state_t      state, state_next;
  logic [1:0]  last, last_next;
  logic [7:0]  count, count_next;
  logic        last_flag, last_flag_next;
  logic        wait_first, wait_first_next;
  logic [1:0]  owner_next;
  logic        owner_valid_next;
  logic [3:0]  ack_next;
  logic [7:0]  tx_data_next;
  logic        tx_start_next;

  logic        grant_hit;
  logic [1:0]  grant_idx;
  logic        owner_req;
  logic        fire;
  logic        wait_done;
  logic        drop_grant;

  assign owner_req  = req[owner];
  assign fire       = (state == LOAD) && owner_req && !tx_busy;
  // tx_busy only rises the cycle after tx_start, so the first WAIT cycle is blind.
  assign wait_done  = (state == WAIT) && !wait_first && !tx_busy;
  assign drop_grant = ((state == LOAD) && !owner_req) ||
                      (wait_done && (last_flag || (count == HOLD_MAX_B)));

  // Scan from last+1 with wrap; i == 4 lands on last itself, giving it lowest priority.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = last;
    for (int i = 1; i <= 4; i++) begin
      if (!grant_hit && req[last + 2'(i)]) begin
        grant_hit = 1'b1;
        grant_idx = last + 2'(i);
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last        <= 2'd3;
      count       <= 8'd0;
      last_flag   <= 1'b0;
      wait_first  <= 1'b0;
      owner       <= 2'd3;
      owner_valid <= 1'b0;
      ack         <= 4'b0000;
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
    end else begin
      state       <= state_next;
      last        <= last_next;
      count       <= count_next;
      last_flag   <= last_flag_next;
      wait_first  <= wait_first_next;
      owner       <= owner_next;
      owner_valid <= owner_valid_next;
      ack         <= ack_next;
      tx_data     <= tx_data_next;
      tx_start    <= tx_start_next;
    end
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (grant_hit) state_next = LOAD;
      LOAD: begin
        if (!owner_req)    state_next = IDLE;
        else if (!tx_busy) state_next = WAIT;
      end
      WAIT: if (wait_done) state_next = drop_grant ? IDLE : LOAD;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    last_next        = last;
    count_next       = count;
    last_flag_next   = last_flag;
    wait_first_next  = 1'b0;
    owner_next       = owner;
    owner_valid_next = owner_valid;
    ack_next         = 4'b0000;
    tx_data_next     = tx_data;
    tx_start_next    = 1'b0;

    if (state == IDLE) begin
      owner_valid_next = grant_hit;
      if (grant_hit) begin
        owner_next = grant_idx;
        count_next = 8'd0;
      end
    end

    if (fire) begin
      tx_data_next    = req_data[{owner, 3'b000} +: 8];
      tx_start_next   = 1'b1;
      ack_next[owner] = 1'b1;
      last_flag_next  = req_last[owner];
      wait_first_next = 1'b1;
      count_next      = (count == 8'hFF) ? count : count + 8'd1;
    end

    if (drop_grant) begin
      owner_valid_next = 1'b0;
      last_next        = owner;
      count_next       = 8'd0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: a default instance and a HOLD_MAX=2 instance
// share the requester inputs; each has its own transmitter busy model.
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = 4'b0;
  logic [31:0] req_data = 32'h0;
  logic [3:0]  req_last = 4'b0;

  logic [3:0]  ack_a, ack_b;
  logic [7:0]  tx_data_a, tx_data_b;
  logic        tx_start_a, tx_start_b;
  logic        busy_a, busy_b;
  logic [1:0]  owner_a, owner_b;
  logic        ov_a, ov_b;

  int tests = 0;
  int fails = 0;
  int busy_len = 10;
  logic force_busy = 1'b0;
  int cnt_a = 0;
  int cnt_b = 0;
  int cycle = 0;

  int q_ack_a[$], q_dat_a[$], q_cyc_a[$], q_gnt_a[$];
  int q_ack_b[$], q_cyc_b[$], q_gnt_b[$];
  logic ov_prev_a = 1'b0, ov_prev_b = 1'b0;
  logic st_prev_a = 1'b0, st_prev_b = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arb dut_a (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack_a), .tx_data(tx_data_a), .tx_start(tx_start_a), .tx_busy(busy_a),
    .owner(owner_a), .owner_valid(ov_a)
  );

  uart_tx_arb #(.HOLD_MAX(2)) dut_b (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack_b), .tx_data(tx_data_b), .tx_start(tx_start_b), .tx_busy(busy_b),
    .owner(owner_b), .owner_valid(ov_b)
  );

  // Transmitter model: busy for busy_len cycles starting the cycle after tx_start.
  assign busy_a = (cnt_a != 0) || force_busy;
  assign busy_b = (cnt_b != 0) || force_busy;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (reset) begin
      cnt_a <= 0;
      cnt_b <= 0;
    end else begin
      if (tx_start_a)      cnt_a <= busy_len;
      else if (cnt_a != 0) cnt_a <= cnt_a - 1;
      if (tx_start_b)      cnt_b <= busy_len;
      else if (cnt_b != 0) cnt_b <= cnt_b - 1;
    end
  end

  function automatic int idx_of(logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Event logger plus per-cycle pulse invariants for both instances.
  always @(posedge clk) begin
    logic bad;
    #1;
    bad = ($countones(ack_a) > 1) || ((ack_a != 4'b0) != tx_start_a) ||
          ((ack_a != 4'b0) && (ack_a != (4'b0001 << owner_a))) || (tx_start_a && st_prev_a);
    tests++;
    if (bad === 1'b1) begin
      fails++;
      $display("FAIL pulse_invariant_a: ack=%b tx_start=%b owner=%0d prev_start=%b, required one-hot ack to owner with single tx_start",
               ack_a, tx_start_a, owner_a, st_prev_a);
    end
    bad = ($countones(ack_b) > 1) || ((ack_b != 4'b0) != tx_start_b) ||
          ((ack_b != 4'b0) && (ack_b != (4'b0001 << owner_b))) || (tx_start_b && st_prev_b);
    tests++;
    if (bad === 1'b1) begin
      fails++;
      $display("FAIL pulse_invariant_b: ack=%b tx_start=%b owner=%0d prev_start=%b, required one-hot ack to owner with single tx_start",
               ack_b, tx_start_b, owner_b, st_prev_b);
    end
    if (ack_a != 4'b0 && ack_a !== 4'bx) begin
      q_ack_a.push_back(idx_of(ack_a));
      q_dat_a.push_back(int'(tx_data_a));
      q_cyc_a.push_back(cycle);
    end
    if (ack_b != 4'b0 && ack_b !== 4'bx) begin
      q_ack_b.push_back(idx_of(ack_b));
      q_cyc_b.push_back(cycle);
    end
    if (ov_a === 1'b1 && ov_prev_a !== 1'b1) q_gnt_a.push_back(int'(owner_a));
    if (ov_b === 1'b1 && ov_prev_b !== 1'b1) q_gnt_b.push_back(int'(owner_b));
    ov_prev_a = ov_a;
    ov_prev_b = ov_b;
    st_prev_a = tx_start_a;
    st_prev_b = tx_start_b;
  end

  task automatic clear_logs();
    q_ack_a.delete(); q_dat_a.delete(); q_cyc_a.delete(); q_gnt_a.delete();
    q_ack_b.delete(); q_cyc_b.delete(); q_gnt_b.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req = 4'b0;
    req_last = 4'b0;
    force_busy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (owner_a !== 2'd3) begin fails++; $display("FAIL reset_owner: got %0d, required 3", owner_a); end
    tests++; if (ov_a !== 1'b0) begin fails++; $display("FAIL reset_owner_valid: got %b, required 0", ov_a); end
    tests++; if (ack_a !== 4'b0) begin fails++; $display("FAIL reset_ack: got %b, required 0000", ack_a); end
    tests++; if (tx_start_a !== 1'b0) begin fails++; $display("FAIL reset_tx_start: got %b, required 0", tx_start_a); end
    tests++; if (tx_data_a !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %h, required 00", tx_data_a); end
    @(negedge clk);
    tests++; if (ov_a !== 1'b0 || owner_a !== 2'd3) begin
      fails++; $display("FAIL idle_no_req: owner_valid=%b owner=%0d, required 0 and 3", ov_a, owner_a);
    end
  endtask

  task automatic test_single_byte();
    do_reset();
    busy_len = 10;
    req = 4'b0100; req_data = 32'h00A5_0000; req_last = 4'b0100;
    @(negedge clk);
    tests++; if (ov_a !== 1'b1 || owner_a !== 2'd2 || tx_start_a !== 1'b0) begin
      fails++; $display("FAIL single_grant: owner_valid=%b owner=%0d tx_start=%b, required 1, 2, 0", ov_a, owner_a, tx_start_a);
    end
    @(negedge clk);
    tests++; if (tx_start_a !== 1'b1 || ack_a !== 4'b0100 || tx_data_a !== 8'hA5) begin
      fails++; $display("FAIL single_start: tx_start=%b ack=%b tx_data=%h, required 1, 0100, a5", tx_start_a, ack_a, tx_data_a);
    end
    req = 4'b0000;
    repeat (11) @(negedge clk);
    tests++; if (ov_a !== 1'b1) begin fails++; $display("FAIL single_hold_while_busy: owner_valid=%b, required 1", ov_a); end
    @(negedge clk);
    tests++; if (ov_a !== 1'b0) begin fails++; $display("FAIL single_release: owner_valid=%b, required 0", ov_a); end
    @(negedge clk);
    tests++; if (owner_a !== 2'd2 || ov_a !== 1'b0 || q_ack_a.size() != 1) begin
      fails++; $display("FAIL single_after: owner=%0d owner_valid=%b acks=%0d, required 2, 0, 1", owner_a, ov_a, q_ack_a.size());
    end
  endtask

  task automatic test_round_robin();
    int exp_rr[5] = '{0, 1, 2, 3, 0};
    do_reset();
    busy_len = 4;
    req = 4'b1111; req_last = 4'b1111; req_data = 32'h1312_1110;
    for (int c = 0; c < 400 && q_ack_a.size() < 5; c++) @(negedge clk);
    tests++;
    if (q_ack_a.size() < 5) begin
      fails++; $display("FAIL rr_timeout: acks=%0d, required 5", q_ack_a.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        tests++; if (q_ack_a[k] != exp_rr[k] || q_dat_a[k] != 'h10 + exp_rr[k]) begin
          fails++; $display("FAIL rr_order[%0d]: ack to %0d data %h, required %0d data %h", k, q_ack_a[k], q_dat_a[k], exp_rr[k], 'h10 + exp_rr[k]);
        end
      end
      tests++; if (q_gnt_a.size() != 5 || q_gnt_a[4] != 0) begin
        fails++; $display("FAIL rr_one_ack_per_grant: grants=%0d, required 5 ending at 0", q_gnt_a.size());
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_packet_lock();
    int n1 = 0;
    int exp_pl[4] = '{1, 1, 1, 3};
    do_reset();
    busy_len = 4;
    req = 4'b1010; req_last = 4'b1000; req_data = 32'hD300_B100;
    for (int c = 0; c < 400 && q_ack_a.size() < 4; c++) begin
      @(negedge clk);
      if (ack_a[1] === 1'b1) begin
        n1++;
        if (n1 == 2) req_last[1] = 1'b1;
        if (n1 == 3) req[1] = 1'b0;
      end
    end
    tests++;
    if (q_ack_a.size() < 4) begin
      fails++; $display("FAIL lock_timeout: acks=%0d, required 4", q_ack_a.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests++; if (q_ack_a[k] != exp_pl[k]) begin
          fails++; $display("FAIL lock_order[%0d]: ack to %0d, required %0d", k, q_ack_a[k], exp_pl[k]);
        end
      end
      tests++; if (q_gnt_a.size() < 2 || q_gnt_a[0] != 1 || q_gnt_a[1] != 3) begin
        fails++; $display("FAIL lock_grants: count=%0d, required grants 1 then 3", q_gnt_a.size());
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_forced_release();
    do_reset();
    busy_len = 4;
    req = 4'b0011; req_last = 4'b0000; req_data = 32'h0000_2211;
    for (int c = 0; c < 400 && q_ack_b.size() < 3; c++) @(negedge clk);
    tests++;
    if (q_ack_b.size() < 3 || q_ack_a.size() < 3) begin
      fails++; $display("FAIL force_timeout: acks_b=%0d acks_a=%0d, required 3 each", q_ack_b.size(), q_ack_a.size());
    end else begin
      tests++; if (q_ack_b[0] != 0 || q_ack_b[1] != 0 || q_ack_b[2] != 1) begin
        fails++; $display("FAIL force_order: acks %0d,%0d,%0d, required 0,0,1", q_ack_b[0], q_ack_b[1], q_ack_b[2]);
      end
      tests++; if (q_gnt_b.size() < 2 || q_gnt_b[0] != 0 || q_gnt_b[1] != 1) begin
        fails++; $display("FAIL force_grants: count=%0d, required grants 0 then 1", q_gnt_b.size());
      end
      tests++; if (q_ack_a[0] != 0 || q_ack_a[1] != 0 || q_ack_a[2] != 0 || q_gnt_a.size() != 1) begin
        fails++; $display("FAIL hold64_no_release: acks %0d,%0d,%0d grants=%0d, required 0,0,0 and 1", q_ack_a[0], q_ack_a[1], q_ack_a[2], q_gnt_a.size());
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_backpressure_withdraw();
    do_reset();
    busy_len = 10;
    force_busy = 1'b1;
    req = 4'b0001; req_last = 4'b0001; req_data = 32'h0000_003C;
    @(negedge clk);
    tests++; if (ov_a !== 1'b1 || owner_a !== 2'd0) begin
      fails++; $display("FAIL bp_grant: owner_valid=%b owner=%0d, required 1, 0", ov_a, owner_a);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests++; if (tx_start_a !== 1'b0 || ack_a !== 4'b0) begin
        fails++; $display("FAIL bp_stall[%0d]: tx_start=%b ack=%b, required 0, 0000", k, tx_start_a, ack_a);
      end
    end
    force_busy = 1'b0;
    @(negedge clk);
    tests++; if (tx_start_a !== 1'b1 || ack_a !== 4'b0001 || tx_data_a !== 8'h3C) begin
      fails++; $display("FAIL bp_resume: tx_start=%b ack=%b tx_data=%h, required 1, 0001, 3c", tx_start_a, ack_a, tx_data_a);
    end
    req = 4'b0000;
    for (int c = 0; c < 40 && ov_a !== 1'b0; c++) @(negedge clk);
    tests++; if (ov_a !== 1'b0) begin fails++; $display("FAIL bp_release_timeout: owner_valid=%b, required 0", ov_a); end
    clear_logs();
    force_busy = 1'b1;
    req = 4'b0010;
    @(negedge clk);
    tests++; if (ov_a !== 1'b1 || owner_a !== 2'd1) begin
      fails++; $display("FAIL wd_grant: owner_valid=%b owner=%0d, required 1, 1", ov_a, owner_a);
    end
    req = 4'b0000;
    @(negedge clk);
    tests++; if (ov_a !== 1'b0 || ack_a !== 4'b0 || tx_start_a !== 1'b0) begin
      fails++; $display("FAIL wd_release: owner_valid=%b ack=%b tx_start=%b, required 0, 0000, 0", ov_a, ack_a, tx_start_a);
    end
    force_busy = 1'b0;
    req = 4'b0110; req_last = 4'b0110;
    @(negedge clk);
    tests++; if (ov_a !== 1'b1 || owner_a !== 2'd2 || q_ack_a.size() != 0) begin
      fails++; $display("FAIL wd_next_grant: owner_valid=%b owner=%0d acks=%0d, required 1, 2, 0", ov_a, owner_a, q_ack_a.size());
    end
    req = 4'b0000;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    busy_len = 10;
    req = 4'b1000; req_last = 4'b0000; req_data = 32'h7700_0011;
    for (int c = 0; c < 20 && q_ack_a.size() < 1; c++) @(negedge clk);
    tests++; if (q_ack_a.size() < 1 || q_ack_a[0] != 3) begin
      fails++; $display("FAIL rst_pre_grant: acks=%0d, required one ack to 3", q_ack_a.size());
    end
    repeat (2) @(negedge clk);
    req = 4'b1001;
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    tests++; if (ov_a !== 1'b1) begin fails++; $display("FAIL rst_async_ignored: owner_valid=%b, required 1", ov_a); end
    @(negedge clk);
    tests++; if (ov_a !== 1'b0 || tx_start_a !== 1'b0 || ack_a !== 4'b0 || owner_a !== 2'd3) begin
      fails++; $display("FAIL rst_abort: owner_valid=%b tx_start=%b ack=%b owner=%0d, required 0, 0, 0000, 3", ov_a, tx_start_a, ack_a, owner_a);
    end
    clear_logs();
    reset = 1'b0;
    @(negedge clk);
    tests++; if (ov_a !== 1'b1 || owner_a !== 2'd0) begin
      fails++; $display("FAIL rst_first_grant: owner_valid=%b owner=%0d, required 1, 0", ov_a, owner_a);
    end
    for (int c = 0; c < 20 && q_ack_a.size() < 1; c++) @(negedge clk);
    tests++; if (q_ack_a.size() < 1 || q_ack_a[0] != 0) begin
      fails++; $display("FAIL rst_first_ack: acks=%0d, required first ack to 0", q_ack_a.size());
    end
    req = 4'b0000;
  endtask

  task automatic test_back_to_back();
    do_reset();
    busy_len = 0;
    req = 4'b0001; req_last = 4'b0000; req_data = 32'h0000_005A;
    for (int c = 0; c < 100 && (q_ack_a.size() < 3 || q_ack_b.size() < 3); c++) @(negedge clk);
    tests++;
    if (q_ack_a.size() < 3 || q_ack_b.size() < 3) begin
      fails++; $display("FAIL b2b_timeout: acks_a=%0d acks_b=%0d, required 3 each", q_ack_a.size(), q_ack_b.size());
    end else begin
      tests++; if (q_cyc_a[1] - q_cyc_a[0] != 3 || q_cyc_a[2] - q_cyc_a[1] != 3) begin
        fails++; $display("FAIL b2b_spacing: gaps %0d,%0d, required 3,3", q_cyc_a[1] - q_cyc_a[0], q_cyc_a[2] - q_cyc_a[1]);
      end
      tests++; if (q_ack_b[2] != 0 || q_cyc_b[2] - q_cyc_b[1] != 4) begin
        fails++; $display("FAIL b2b_regrant_gap: ack to %0d gap %0d, required 0 and 4", q_ack_b[2], q_cyc_b[2] - q_cyc_b[1]);
      end
      tests++; if (q_gnt_b.size() < 2 || q_gnt_b[1] != 0) begin
        fails++; $display("FAIL b2b_sole_regrant: grants=%0d, required second grant to 0", q_gnt_b.size());
      end
    end
    req = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_round_robin();
    test_packet_lock();
    test_forced_release();
    test_backpressure_withdraw();
    test_reset_mid_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Parameters
REQ-001 SHALL provide parameter HOLD_MAX, default 64: maximum bytes one owner may send before forced release, legal range 1..255.

Interface
REQ-002 SHALL have port clk, input, 1: system clock (32 MHz).
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port req, input, 4: per-requester byte-pending flag; must be held until the matching ack.
REQ-005 SHALL have port req_data, input, 32: requester i's byte is on bits [8i+7:8i].
REQ-006 SHALL have port req_last, input, 4: the current byte of requester i ends its packet.
REQ-007 SHALL have port ack, output, 4: one-cycle pulse to requester i when its byte is handed to the transmitter.
REQ-008 SHALL have port tx_data, output, 8: byte to the UART transmitter.
REQ-009 SHALL have port tx_start, output, 1: one-cycle start pulse to the UART transmitter.
REQ-010 SHALL have port tx_busy, input, 1: transmitter is shifting a frame; it rises the cycle after tx_start.
REQ-011 SHALL have port owner, output, 2: index of the current grant holder.
REQ-012 SHALL have port owner_valid, output, 1: a grant is held.

Function
REQ-013 SHALL implement the FSM states IDLE, LOAD and WAIT, with every output registered.
REQ-014 In IDLE with req != 0, SHALL select the first set bit scanning from (last+1) mod 4 upward with wrap, register owner, set owner_valid, and enter LOAD next cycle; req asserted in cycle n gives owner_valid=1 in cycle n+1.
REQ-015 In IDLE with req == 0, SHALL remain in IDLE with owner_valid=0 and owner holding its previous value.
REQ-016 In LOAD with req[owner]=1 and tx_busy=0, SHALL in one cycle:
- drive tx_data=req_data[owner]
- pulse tx_start and ack[owner]
- latch req_last[owner] into last_flag
- increment the byte count
- enter WAIT
REQ-017 In LOAD with tx_busy=1, SHALL stall with no pulses.
REQ-018 In LOAD with req[owner]=0, SHALL release the grant (owner_valid=0, last=owner) and return to IDLE without transmitting.
REQ-019 WAIT SHALL ignore tx_busy on its first cycle, then wait for tx_busy=0.
REQ-020 On WAIT exit with last_flag=1 or count==HOLD_MAX, SHALL release: owner_valid=0, last=owner, count=0, go to IDLE.
REQ-021 On WAIT exit in any other case, SHALL return to LOAD holding the grant.
REQ-022 The byte count SHALL be 8 bits, clear on every grant, and never wrap.
REQ-023 At most one ack bit and at most one tx_start SHALL be high in any cycle; ack SHALL coincide exactly with tx_start.
REQ-024 Changes on non-owner req bits while a grant is held SHALL have no effect until release.
REQ-025 After a release, the released requester SHALL have lowest priority in the next arbitration, including when it is the only requester (it is then re-granted).
REQ-026 Minimum byte-to-byte spacing for one owner SHALL be tx_start, then ≥2 WAIT cycles, then LOAD; there SHALL be no back-to-back tx_start.

Reset
REQ-027 While reset=1 at a clk edge, SHALL set state=IDLE, ack=0, tx_start=0, tx_data=8'h00, owner=2'd3, owner_valid=0, last=3, count=0, last_flag=0.
REQ-028 Reset asserted mid-transfer SHALL abort the grant with no further ack/tx_start; the first grant after reset SHALL go to requester 0 when it is requesting.
REQ-029 Reset SHALL be sampled only on clk edges; asynchronous assertion SHALL have no effect before the next edge.

Verification
REQ-030 Single byte: req=4'b0100, req_data[23:16]=8'hA5, req_last[2]=1, tx_busy model of 10 cycles ->
- owner_valid=1 and owner=2 one cycle later
- tx_start and ack=4'b0100 in the following cycle, with tx_data=8'hA5
- release after tx_busy falls
REQ-031 Round robin: req=4'b1111 held, every byte last -> grant order 0,1,2,3,0; exactly one ack per grant.
REQ-032 Packet lock: requester 1 sends 3 bytes (last on the 3rd) while req[3]=1 -> three consecutive acks to 1, then owner=3.
REQ-033 Forced release: HOLD_MAX=2, requester 0 never asserts last, req[1]=1 -> two acks to 0, then grant to 1.
REQ-034 Backpressure/withdraw: tx_busy held 1 in LOAD -> no tx_start until it drops; req[owner] dropped in LOAD -> release with no ack.
REQ-035 Reset mid-WAIT: reset=1 for one cycle -> next cycle owner_valid=0, tx_start=0, ack=0; with req=4'b1001 the next grant is requester 0.
